// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: one-word holding register feeding a shift register,
// emitting one bit per clock on out with zero-gap streaming between held words.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_nxt_s;
    logic [WIDTH-1:0] sreg_r;
    logic [WIDTH-1:0] sreg_nxt_s;
    logic [WIDTH-1:0] hold_r;
    logic [WIDTH-1:0] hold_nxt_s;
    logic             hold_full_r;
    logic             hold_full_nxt_s;
    logic             last_s;
    logic             xfer_s;
    logic             load_s;

    // Advance the shift register by one bit toward the transmit end.
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] word);
        logic [WIDTH-1:0] res;
        if (MSB_FIRST) begin
            res = {word[WIDTH-2:0], 1'b0};
        end else begin
            res = {1'b0, word[WIDTH-1:1]};
        end
        return res;
    endfunction

    assign last_s     = (state_r == SHIFT) && (cnt_r == LAST_CNT);
    assign xfer_s     = hold_full_r && ((state_r == IDLE) || last_s);
    assign load_ready = !hold_full_r || xfer_s;
    assign load_s     = load_valid && load_ready;

    // Next-state for the FSM, bit counter and shift register.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        sreg_nxt_s  = sreg_r;
        case (state_r)
            IDLE: begin
                if (xfer_s) begin
                    sreg_nxt_s  = hold_r;
                    cnt_nxt_s   = {CW{1'b0}};
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (xfer_s) begin
                    sreg_nxt_s  = hold_r;
                    cnt_nxt_s   = {CW{1'b0}};
                    state_nxt_s = SHIFT;
                end else if (last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    cnt_nxt_s  = cnt_r + CW'(1);
                    sreg_nxt_s = shift_word(sreg_r);
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Holding register: a same-edge load wins over the outgoing transfer.
    always_comb begin
        hold_nxt_s      = hold_r;
        hold_full_nxt_s = hold_full_r;
        if (load_s) begin
            hold_nxt_s      = data_in;
            hold_full_nxt_s = 1'b1;
        end else if (xfer_s) begin
            hold_full_nxt_s = 1'b0;
        end else begin
            hold_full_nxt_s = hold_full_r;
        end
    end

    // State registers with immediate abort on reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            sreg_r      <= {WIDTH{1'b0}};
            hold_r      <= {WIDTH{1'b0}};
            hold_full_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            sreg_r      <= sreg_nxt_s;
            hold_r      <= hold_nxt_s;
            hold_full_r <= hold_full_nxt_s;
        end
    end

    assign out_valid = (state_r == SHIFT);
    assign word_done = last_s;
    assign busy      = (state_r == SHIFT) || hold_full_r;
    assign out       = (state_r == SHIFT) ? (MSB_FIRST ? sreg_r[WIDTH-1] : sreg_r[0]) : IDLE_BIT;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: an MSB-first and an LSB-first instance share
// clock and reset; every expected bit is written out by hand from the test words.
module tb_bit_serializer;

    logic       clock;
    logic       reset;
    logic [7:0] data_m;
    logic       valid_m;
    logic       ready_m;
    logic       out_m;
    logic       ovalid_m;
    logic       busy_m;
    logic       done_m;
    logic [7:0] data_l;
    logic       valid_l;
    logic       ready_l;
    logic       out_l;
    logic       ovalid_l;
    logic       busy_l;
    logic       done_l;

    int checks;
    int errors;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
        .clock(clock), .reset(reset), .data_in(data_m), .load_valid(valid_m),
        .load_ready(ready_m), .out(out_m), .out_valid(ovalid_m), .busy(busy_m),
        .word_done(done_m)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
        .clock(clock), .reset(reset), .data_in(data_l), .load_valid(valid_l),
        .load_ready(ready_l), .out(out_l), .out_valid(ovalid_l), .busy(busy_l),
        .word_done(done_l)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if ({out_m, ovalid_m, busy_m, done_m, ready_m} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_state_m got=%b exp=00001", {out_m, ovalid_m, busy_m, done_m, ready_m});
        end
        checks++;
        if ({out_l, ovalid_l, busy_l, done_l, ready_l} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_state_l got=%b exp=00001", {out_l, ovalid_l, busy_l, done_l, ready_l});
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checks++;
            if ({out_m, ovalid_m, busy_m, done_m, ready_m} !== 5'b00001) begin
                errors++;
                $display("FAIL idle_cycle_%0d got=%b exp=00001", i, {out_m, ovalid_m, busy_m, done_m, ready_m});
            end
        end
    endtask

    task automatic test_single_msb();
        logic [7:0] w;
        w = 8'hA5;
        data_m  = w;
        valid_m = 1'b1;
        @(negedge clock);
        valid_m = 1'b0;
        checks++;
        if ({ovalid_m, busy_m} !== 2'b01) begin
            errors++;
            $display("FAIL single_accept_cycle got=%b exp=01", {ovalid_m, busy_m});
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            checks++;
            if ({out_m, ovalid_m, done_m} !== {w[7-i], 1'b1, (i == 7)}) begin
                errors++;
                $display("FAIL single_bit_%0d got=%b exp=%b", i, {out_m, ovalid_m, done_m}, {w[7-i], 1'b1, (i == 7)});
            end
        end
        @(negedge clock);
        checks++;
        if ({out_m, ovalid_m, busy_m, done_m} !== 4'b0000) begin
            errors++;
            $display("FAIL single_end got=%b exp=0000", {out_m, ovalid_m, busy_m, done_m});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] s;
        s = 16'hA53C;
        data_m  = 8'hA5;
        valid_m = 1'b1;
        @(negedge clock);
        data_m = 8'h3C;
        checks++;
        if (ready_m !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_at_xfer got=%b exp=1", ready_m);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            if (i == 0) valid_m = 1'b0;
            checks++;
            if ({out_m, ovalid_m, done_m, ready_m} !== {s[15-i], 1'b1, (i == 7 || i == 15), (i >= 7)}) begin
                errors++;
                $display("FAIL b2b_bit_%0d got=%b exp=%b", i, {out_m, ovalid_m, done_m, ready_m},
                         {s[15-i], 1'b1, (i == 7 || i == 15), (i >= 7)});
            end
        end
        @(negedge clock);
        checks++;
        if ({ovalid_m, busy_m} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_end got=%b exp=00", {ovalid_m, busy_m});
        end
    endtask

    task automatic test_late_load_gap();
        logic [7:0] a;
        logic [7:0] b;
        a = 8'hA5;
        b = 8'h3C;
        data_m  = a;
        valid_m = 1'b1;
        @(negedge clock);
        valid_m = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (i == 7) begin
                data_m  = b;
                valid_m = 1'b1;
                checks++;
                if ({done_m, ready_m, busy_m} !== 3'b111) begin
                    errors++;
                    $display("FAIL gap_last_cycle got=%b exp=111", {done_m, ready_m, busy_m});
                end
            end
        end
        @(negedge clock);
        valid_m = 1'b0;
        checks++;
        if ({out_m, ovalid_m, busy_m} !== 3'b001) begin
            errors++;
            $display("FAIL gap_idle_cycle got=%b exp=001", {out_m, ovalid_m, busy_m});
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            checks++;
            if ({out_m, ovalid_m, done_m} !== {b[7-i], 1'b1, (i == 7)}) begin
                errors++;
                $display("FAIL gap_bit_%0d got=%b exp=%b", i, {out_m, ovalid_m, done_m}, {b[7-i], 1'b1, (i == 7)});
            end
        end
        @(negedge clock);
    endtask

    task automatic test_lsb_first();
        logic [7:0] exp_bits;
        exp_bits = 8'b1000_0000;
        data_l  = 8'h01;
        valid_l = 1'b1;
        @(negedge clock);
        valid_l = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            checks++;
            if ({out_l, ovalid_l, done_l} !== {exp_bits[7-i], 1'b1, (i == 7)}) begin
                errors++;
                $display("FAIL lsb_bit_%0d got=%b exp=%b", i, {out_l, ovalid_l, done_l}, {exp_bits[7-i], 1'b1, (i == 7)});
            end
        end
        @(negedge clock);
        checks++;
        if ({out_l, ovalid_l, busy_l} !== 3'b000) begin
            errors++;
            $display("FAIL lsb_end got=%b exp=000", {out_l, ovalid_l, busy_l});
        end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] w;
        w = 8'h80;
        data_m  = 8'hFF;
        valid_m = 1'b1;
        @(negedge clock);
        data_m = 8'h0F;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (i == 0) valid_m = 1'b0;
        end
        checks++;
        if ({out_m, ovalid_m, busy_m} !== 3'b111) begin
            errors++;
            $display("FAIL rst_before got=%b exp=111", {out_m, ovalid_m, busy_m});
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({out_m, ovalid_m, busy_m, done_m, ready_m} !== 5'b00001) begin
            errors++;
            $display("FAIL rst_abort got=%b exp=00001", {out_m, ovalid_m, busy_m, done_m, ready_m});
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if ({out_m, ovalid_m, busy_m} !== 3'b000) begin
                errors++;
                $display("FAIL rst_no_stale_%0d got=%b exp=000", i, {out_m, ovalid_m, busy_m});
            end
        end
        data_m  = w;
        valid_m = 1'b1;
        @(negedge clock);
        valid_m = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            checks++;
            if ({out_m, ovalid_m} !== {w[7-i], 1'b1}) begin
                errors++;
                $display("FAIL rst_reload_bit_%0d got=%b exp=%b", i, {out_m, ovalid_m}, {w[7-i], 1'b1});
            end
        end
        @(negedge clock);
        checks++;
        if ({ovalid_m, busy_m} !== 2'b00) begin
            errors++;
            $display("FAIL rst_reload_end got=%b exp=00", {ovalid_m, busy_m});
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        data_m  = 8'h00;
        valid_m = 1'b0;
        data_l  = 8'h00;
        valid_l = 1'b0;
        test_reset();
        test_single_msb();
        test_back_to_back();
        test_late_load_gap();
        test_lsb_first();
        test_reset_mid_word();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
